// File: rtl/faccel_host.sv
// Host-side sequencer for the factorial accelerator register port (write N, write GO, poll STATUS, read FACT).
// Latency: 7 cycles from accepted start to done when STATUS is set on the first poll. No backpressure: start is ignored while busy.
module faccel_host #(
  parameter int TIMEOUT = 1024,
  parameter int CW      = 11
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [3:0]  i_n,
  output logic        o_wel,
  output logic [1:0]  o_a,
  output logic [3:0]  o_d,
  input  logic [31:0] i_rdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result,
  output logic        o_ovf,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_N, S_WR_G, S_SETTLE, S_POLL, S_RD_ADDR, S_RD_DATA, S_FIN
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      o_wel    <= 1'b0;
      o_a      <= 2'd0;
      o_d      <= 4'd0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= 32'd0;
      o_ovf    <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        // FIN also accepts start so a held request issues WR_N right after the done cycle.
        S_IDLE, S_FIN: begin
          if (i_start) begin
            r_state  <= S_WR_N;
            o_wel    <= 1'b1;
            o_a      <= 2'd0;
            o_d      <= i_n;
            o_busy   <= 1'b1;
            o_ovf    <= (i_n > 4'd12);
            o_err    <= 1'b0;
            o_result <= 32'd0;
          end else begin
            r_state <= S_IDLE;
            o_wel   <= 1'b0;
            o_a     <= 2'd0;
          end
        end
        S_WR_N: begin
          r_state <= S_WR_G;
          o_wel   <= 1'b1;
          o_a     <= 2'd1;
          o_d     <= 4'b0001;
        end
        S_WR_G: begin
          r_state <= S_SETTLE;
          o_wel   <= 1'b0;
          o_a     <= 2'd2;
        end
        S_SETTLE: begin
          r_state <= S_POLL;
          r_cnt   <= '0;
          o_a     <= 2'd2;
        end
        S_POLL: begin
          if (i_rdata[0]) begin
            r_state <= S_RD_ADDR;
            o_a     <= 2'd3;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_state <= S_FIN;
            o_err   <= 1'b1;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            o_a     <= 2'd0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RD_ADDR: begin
          r_state <= S_RD_DATA;
          o_a     <= 2'd3;
        end
        S_RD_DATA: begin
          r_state  <= S_FIN;
          o_result <= i_rdata;
          o_done   <= 1'b1;
          o_busy   <= 1'b0;
          o_a      <= 2'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
